face_instr_fetch: RTL and testbench
===================================

Name: face_instr_fetch

Overview:
Parametrised instruction fetch unit for the FACE accelerator, replacing the free-running PC plus fixed half-word select.
- Issues reads to the synchronous instruction ROM and buffers returned words in a prefetch FIFO.
- Unpacks each word into INSTR_W-bit instructions, most-significant lane first, and hands them to FACE_TOP over a valid/ready handshake.
- Supports start at any lane-aligned address, restart mid-run, halt-instruction detection and backpressure without loss.

Parameters:
INSTR_W, 32, instruction width in bits.
WORD_W, 64, ROM word width; must be an integer multiple of INSTR_W. LANES = WORD_W/INSTR_W.
ADDR_W, 32, byte-address width.
FIFO_DEPTH, 4, prefetch depth in ROM words; power of 2, >= 2.
HALT_INSTR, 32'hFFFF_FFFF, instruction value that ends the program.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin or restart fetch at start_addr
start_addr  in  ADDR_W  byte address of first instruction; low log2(INSTR_W/8) bits ignored
rom_ren  out  1  ROM read enable
rom_raddr  out  ADDR_W  ROM byte address, WORD_W/8-aligned
rom_rdata  in  WORD_W  ROM data, valid the cycle after rom_ren is sampled
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  consumer accepts (FACE_TOP !busy)
instr  out  INSTR_W  current instruction; 0 when !instr_valid
instr_pc  out  ADDR_W  byte address of instr
running  out  1  fetching or delivering
halted  out  1  HALT_INSTR delivered; sticky until start
fetch_count  out  32  instructions accepted since last start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset, all outputs are 0; the FSM enters IDLE; the FIFO is empty and the in-flight flag is cleared.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> HALTED when a beat with instr==HALT_INSTR is accepted (valid&ready).
  - HALTED -> RUN on start.
  - RUN -> RUN on start (restart).
- Start, sampled at edge k:
  - Flush FIFO and clear fetch_count.
  - The in-flight read return at edge k+1, if any, is discarded via a kill flag.
  - Set first_lane = start_addr lane bits and next fetch address = start_addr aligned down to WORD_W/8.
  - In the cycle after edge k: rom_ren=1, rom_raddr=aligned address.
  - Word enters FIFO at edge k+2, so instr_valid=1 in the cycle after edge k+2.
  - Start-to-first-valid latency is 2 cycles.
- Read issue: rom_ren asserted in RUN only when (fifo_count + inflight) < FIFO_DEPTH. Each issued read advances the fetch address by WORD_W/8. Address wrap at 2^ADDR_W is natural modulo.
- Throughput: sustains one instruction per cycle under continuous instr_ready.
- Unpack:
  - instr = FIFO head word slice [WORD_W-1-lane*INSTR_W -: INSTR_W].
  - instr_pc = head word address + lane*(INSTR_W/8).
  - On accept: lane increments. At lane LANES-1, the word pops and lane resets to 0.
  - The first word after a start uses first_lane; lanes below it are never presented.
- Handshake: instr/instr_pc are held stable while instr_valid & !instr_ready. instr_valid never drops without an accept, except on start or reset.
- Halt:
  - On accept of HALT_INSTR: halted=1 and running=0 next cycle; FIFO flushed; in-flight read killed; rom_ren=0.
  - Remaining lanes of that word are not delivered. fetch_count includes the halt instruction.
- Simultaneous start and accept: the accept completes (counted for the old run, then the counter is cleared); start wins for all state.
- Start in IDLE/HALTED: identical to restart. start_addr is sampled only on the start pulse.
- fetch_count increments on every accept and saturates at 2^32-1.
- running=1 in RUN.

Decomposition:
- Package face_fetch_pkg:
  - fetch_state_e {IDLE, RUN, HALTED}
  - localparams LANES, LANE_BITS, BYTES_PER_WORD, BYTES_PER_INSTR
  - function lane_slice(word, lane)
- Sub-module face_fetch_fifo: synchronous FIFO.
  - Stores {word_addr, word}; FIFO_DEPTH entries.
  - Ports: push, pop, flush, count, head, full, empty.
  - push and pop in the same cycle are legal when non-empty.

Test Plan:
- ROM[0x0]=0x11111111_22222222, ROM[0x8]=0x33333333_44444444; start, start_addr=0x0, instr_ready=1 -> instr_valid rises 2 cycles after start, then one beat per cycle: 0x11111111@0x0, 0x22222222@0x4, 0x33333333@0x8, 0x44444444@0xC.
- Start with start_addr=0x4 -> first beat 0x22222222@0x4, rom_raddr=0x0; 0x11111111 is never presented.
- Backpressure: instr_ready=0 for 12 cycles after first valid -> rom_ren low once 4 words are held; instr stable; on release the full sequence is delivered with no gaps or duplicates.
- Halt: ROM[0x10]=0xFFFFFFFF_55555555 -> after 0xFFFFFFFF@0x10 is accepted, halted=1, running=0, fetch_count=5; 0x55555555 never valid.
- Restart with start_addr=0x8 on the cycle a read to 0x10 returns -> stale word dropped; next beat 0x33333333@0x8; fetch_count=0 before the first accept.
- Assert rst_n=0 mid-stream for 1 cycle -> all outputs 0 immediately; no instr_valid until the next start.

Source files
------------

// File: rtl/face_fetch_pkg.sv
// Shared types and helpers for the FACE instruction fetch unit.
//   fetch_state_e : fetch FSM states
//   *_DEF, LANES, LANE_BITS, BYTES_PER_* : default geometry (32-bit instr, 64-bit word)
//   lane_slice()  : extracts lane `lane` of a word, most-significant lane first
package face_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int INSTR_W_DEF     = 32;
  localparam int WORD_W_DEF      = 64;
  localparam int LANES           = WORD_W_DEF / INSTR_W_DEF;
  localparam int LANE_BITS       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BYTES_PER_WORD  = WORD_W_DEF / 8;
  localparam int BYTES_PER_INSTR = INSTR_W_DEF / 8;

  // Widest word the slice helper handles; callers truncate the result.
  localparam int SLICE_MAX_W = 1024;

  // Lane 0 is the top INSTR_W bits of the word, so shift the wanted lane
  // down to bit 0 and let the caller keep the low instr_w bits.
  function automatic logic [SLICE_MAX_W-1:0] lane_slice(
    input logic [SLICE_MAX_W-1:0] word,
    input int unsigned            lane,
    input int unsigned            instr_w,
    input int unsigned            word_w
  );
    return word >> (word_w - (lane + 1) * instr_w);
  endfunction

endpackage

// File: rtl/face_fetch_fifo.sv
// Prefetch FIFO holding {word_addr, word} entries.
//   push/push_data : write an entry (accepted when not full, or when popping)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop
//   count/head/full/empty : occupancy and show-ahead head entry
module face_fetch_fifo #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/face_instr_fetch.sv
// FACE instruction fetch unit.
//   start/start_addr : begin or restart fetching at a lane-aligned byte address
//   rom_*            : synchronous ROM read port (data one cycle after rom_ren)
//   instr_*          : valid/ready instruction stream, most-significant lane first
//   running/halted   : FSM status; halted is sticky until the next start
//   fetch_count      : saturating count of accepted instructions since start
module face_instr_fetch
  import face_fetch_pkg::*;
#(
  parameter int                 INSTR_W    = INSTR_W_DEF,
  parameter int                 WORD_W     = WORD_W_DEF,
  parameter int                 ADDR_W     = 32,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic               rom_ren,
  output logic [ADDR_W-1:0]  rom_raddr,
  input  logic [WORD_W-1:0]  rom_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               running,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  localparam int NLANES   = WORD_W / INSTR_W;
  localparam int LBITS    = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int WBYTES   = WORD_W / 8;
  localparam int IB_SHIFT = $clog2(INSTR_W / 8);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W  = ADDR_W + WORD_W;
  localparam logic [LBITS-1:0] LAST_LANE = LBITS'(NLANES - 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]  ret_addr_q, ret_addr_d;
  logic [LBITS-1:0]   lane_q, lane_d;
  logic               inflight_q, inflight_d;
  logic               kill_q, kill_d;
  logic [31:0]        count_q, count_d;

  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic [ADDR_W-1:0]  head_addr;
  logic [WORD_W-1:0]  head_word;
  logic [INSTR_W-1:0] lane_instr;
  logic               valid_c, accept, halt_acc, ren_c;
  logic [LBITS-1:0]   start_lane;

  // A return is pushed unless a start/halt in the issuing cycle killed it.
  assign fifo_push  = inflight_q && !kill_q;
  assign fifo_pop   = accept && (lane_q == LAST_LANE);
  assign fifo_flush = start || halt_acc;

  face_fetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({ret_addr_q, rom_rdata}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_addr  = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign head_word  = fifo_head[WORD_W-1:0];
  assign lane_instr = INSTR_W'(lane_slice(SLICE_MAX_W'(head_word), 32'(lane_q),
                                          INSTR_W, WORD_W));

  assign valid_c  = (state_q == RUN) && !fifo_empty;
  assign accept   = valid_c && instr_ready;
  assign halt_acc = accept && (lane_instr == HALT_INSTR);
  // The in-flight read already owns a FIFO slot, so count it against depth.
  assign ren_c    = (state_q == RUN) && !fifo_full &&
                    ((32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH));
  assign start_lane = (NLANES > 1) ? LBITS'(start_addr >> IB_SHIFT) : '0;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (halt_acc) state_d = HALTED;
      HALTED:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    ret_addr_d   = ret_addr_q;
    lane_d       = lane_q;
    count_d      = count_q;
    inflight_d   = ren_c;
    kill_d       = start || halt_acc;
    if (ren_c) ret_addr_d = fetch_addr_q;

    if (start) begin
      fetch_addr_d = start_addr & ~ADDR_W'(WBYTES - 1);
      lane_d       = start_lane;
      count_d      = '0;
    end else begin
      if (ren_c) fetch_addr_d = fetch_addr_q + ADDR_W'(WBYTES);
      if (halt_acc)    lane_d = '0;
      else if (accept) lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LBITS'(1);
      if (accept && (count_q != '1)) count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      ret_addr_q   <= '0;
      lane_q       <= '0;
      inflight_q   <= 1'b0;
      kill_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      ret_addr_q   <= ret_addr_d;
      lane_q       <= lane_d;
      inflight_q   <= inflight_d;
      kill_q       <= kill_d;
      count_q      <= count_d;
    end
  end

  assign rom_ren     = ren_c;
  assign rom_raddr   = fetch_addr_q;
  assign instr_valid = valid_c;
  assign instr       = valid_c ? lane_instr : '0;
  assign instr_pc    = valid_c ? head_addr + (ADDR_W'(lane_q) << IB_SHIFT) : '0;
  assign running     = (state_q == RUN);
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_face_instr_fetch.sv
module tb_face_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        rom_ren;
  logic [31:0] rom_raddr;
  logic [63:0] rom_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        running;
  logic        halted;
  logic [31:0] fetch_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] rom_mem [0:7];

  face_instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .rom_ren     (rom_ren),
    .rom_raddr   (rom_raddr),
    .rom_rdata   (rom_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .running     (running),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data valid the cycle after rom_ren is sampled.
  always @(posedge clk) begin
    if (rom_ren) rom_rdata <= rom_mem[rom_raddr[5:3]];
  end

  // One line per accepted instruction.
  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready)
      $display("[TB] beat instr=%h pc=%h count=%0d", instr, instr_pc, fetch_count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; returns at #1 after the edge that sampled start.
  task automatic do_start(input logic [31:0] addr);
    start_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({instr_valid, rom_ren, running, halted} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got v=%b ren=%b run=%b halt=%b, want all 0",
               instr_valid, rom_ren, running, halted);
    end
    tests_run++;
    if ({instr, instr_pc, rom_raddr, fetch_count} !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_buses: got instr=%h pc=%h raddr=%h cnt=%0d, want 0",
               instr, instr_pc, rom_raddr, fetch_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [4];
    logic [31:0] exp_p [4];
    exp_i = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    exp_p = '{32'h0, 32'h4, 32'h8, 32'hC};
    instr_ready = 1'b1;
    do_start(32'h0);
    tests_run++;
    if (rom_ren !== 1'b1 || rom_raddr !== 32'h0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_first_read: got ren=%b raddr=%h v=%b, want ren=1 raddr=0 v=0",
               rom_ren, rom_raddr, instr_valid);
    end
    tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_latency: got valid=%b one cycle after start, want 0", instr_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== exp_i[i] || instr_pc !== exp_p[i]) begin
        tests_failed++;
        $display("FAIL seq_beat%0d: got v=%b %h@%h, want v=1 %h@%h",
                 i, instr_valid, instr, instr_pc, exp_i[i], exp_p[i]);
      end
      tick();
    end
  endtask

  // Continues from test_sequential: head is now the halt word at 0x10.
  task automatic test_halt();
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hFFFFFFFF || instr_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL halt_beat: got v=%b %h@%h, want v=1 ffffffff@00000010",
               instr_valid, instr, instr_pc);
    end
    tick();
    tests_run++;
    if (halted !== 1'b1 || running !== 1'b0 || fetch_count !== 32'd5 || rom_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_state: got halt=%b run=%b cnt=%0d ren=%b, want 1 0 5 0",
               halted, running, fetch_count, rom_ren);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== 1'b0 || instr !== 32'h0) begin
        tests_failed++;
        $display("FAIL halt_no_more%0d: got v=%b instr=%h, want v=0 instr=0",
                 i, instr_valid, instr);
      end
      tick();
    end
  endtask

  task automatic test_start_offset();
    logic [31:0] exp_i [4];
    logic [31:0] exp_p [4];
    exp_i = '{32'h22222222, 32'h33333333, 32'h44444444, 32'hFFFFFFFF};
    exp_p = '{32'h4, 32'h8, 32'hC, 32'h10};
    instr_ready = 1'b1;
    do_start(32'h4);
    tests_run++;
    if (rom_ren !== 1'b1 || rom_raddr !== 32'h0 || halted !== 1'b0 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL offset_read: got ren=%b raddr=%h halt=%b run=%b, want 1 0 0 1",
               rom_ren, rom_raddr, halted, running);
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== exp_i[i] || instr_pc !== exp_p[i]) begin
        tests_failed++;
        $display("FAIL offset_beat%0d: got v=%b %h@%h, want v=1 %h@%h",
                 i, instr_valid, instr, instr_pc, exp_i[i], exp_p[i]);
      end
      tick();
    end
    tests_run++;
    if (halted !== 1'b1 || fetch_count !== 32'd4) begin
      tests_failed++;
      $display("FAIL offset_halt: got halt=%b cnt=%0d, want 1 4", halted, fetch_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_i [5];
    logic [31:0] exp_p [5];
    int          ren_seen;
    logic        stable_ok;
    exp_i = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hFFFFFFFF};
    exp_p = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    instr_ready = 1'b0;
    ren_seen = 0;
    stable_ok = 1'b1;
    do_start(32'h0);
    for (int i = 0; i < 2; i++) begin
      if (rom_ren) ren_seen++;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      if (rom_ren) ren_seen++;
      if (instr_valid !== 1'b1 || instr !== 32'h11111111 || instr_pc !== 32'h0)
        stable_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (!stable_ok) begin
      tests_failed++;
      $display("FAIL bp_stable: got v=%b %h@%h during stall, want v=1 11111111@00000000",
               instr_valid, instr, instr_pc);
    end
    tests_run++;
    if (ren_seen !== 4 || rom_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ren: got %0d reads, ren=%b, want 4 reads, ren=0", ren_seen, rom_ren);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== exp_i[i] || instr_pc !== exp_p[i]) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got v=%b %h@%h, want v=1 %h@%h",
                 i, instr_valid, instr, instr_pc, exp_i[i], exp_p[i]);
      end
      tick();
    end
    tests_run++;
    if (halted !== 1'b1 || fetch_count !== 32'd5) begin
      tests_failed++;
      $display("FAIL bp_halt: got halt=%b cnt=%0d, want 1 5", halted, fetch_count);
    end
  endtask

  task automatic test_restart();
    logic [31:0] exp_i [3];
    logic [31:0] exp_p [3];
    exp_i = '{32'h33333333, 32'h44444444, 32'hFFFFFFFF};
    exp_p = '{32'h8, 32'hC, 32'h10};
    instr_ready = 1'b1;
    do_start(32'h0);
    repeat (3) tick();
    // Read to 0x10 returns this cycle; 0x22222222 is accepted on the same edge.
    start_addr = 32'h8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (fetch_count !== 32'd0 || instr_valid !== 1'b0 || rom_raddr !== 32'h8 || rom_ren !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_clear: got cnt=%0d v=%b raddr=%h ren=%b, want 0 0 8 1",
               fetch_count, instr_valid, rom_raddr, rom_ren);
    end
    tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_kill: got valid=%b instr=%h, want valid=0", instr_valid, instr);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== exp_i[i] || instr_pc !== exp_p[i]) begin
        tests_failed++;
        $display("FAIL restart_beat%0d: got v=%b %h@%h, want v=1 %h@%h",
                 i, instr_valid, instr, instr_pc, exp_i[i], exp_p[i]);
      end
      tick();
    end
    tests_run++;
    if (halted !== 1'b1 || fetch_count !== 32'd3) begin
      tests_failed++;
      $display("FAIL restart_halt: got halt=%b cnt=%0d, want 1 3", halted, fetch_count);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet_ok;
    instr_ready = 1'b1;
    quiet_ok = 1'b1;
    do_start(32'h0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({instr_valid, rom_ren, running, halted} !== 4'b0000 ||
        {instr, instr_pc, rom_raddr, fetch_count} !== 128'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: got v=%b ren=%b run=%b cnt=%0d instr=%h, want all 0",
               instr_valid, rom_ren, running, fetch_count, instr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (instr_valid !== 1'b0 || rom_ren !== 1'b0 || running !== 1'b0) quiet_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (!quiet_ok) begin
      tests_failed++;
      $display("FAIL midreset_idle: got v=%b ren=%b run=%b after reset, want 0 0 0",
               instr_valid, rom_ren, running);
    end
    do_start(32'h8);
    tick();
    tick();
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'h33333333 || instr_pc !== 32'h8) begin
      tests_failed++;
      $display("FAIL midreset_restart: got v=%b %h@%h, want v=1 33333333@00000008",
               instr_valid, instr, instr_pc);
    end
  endtask

  initial begin
    rom_mem[0] = 64'h11111111_22222222;
    rom_mem[1] = 64'h33333333_44444444;
    rom_mem[2] = 64'hFFFFFFFF_55555555;
    rom_mem[3] = 64'h66666666_77777777;
    for (int i = 4; i < 8; i++) rom_mem[i] = 64'hAAAAAAAA_BBBBBBBB;

    test_reset();
    test_sequential();
    test_halt();
    test_start_offset();
    test_backpressure();
    test_restart();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
